// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-lane data memory:
//   - access-size encodings used on the `size` port
//   - controller state encoding (CLEAR engine / READY)
//   - alignment helper used by the top level
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Half accesses need an even offset; word (and the reserved size, which
  // behaves as word) need offset 0. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load extractor: picks the byte/half addressed by `offset`
// out of a 32-bit little-endian word and sign- or zero-extends it.
// Ports:
//   word         in  32  source word (lane 0 = bits [7:0])
//   offset       in  2   byte offset within the word
//   size         in  2   access size (byte / half / word, 11 acts as word)
//   unsignedLoad in  1   1 = zero-extend, 0 = sign-extend
//   result       out 32  extended load value
// -----------------------------------------------------------------------------
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane(s) and extend to 32 bits.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = word;
    case (offset)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      SZ_BYTE: result = unsignedLoad ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: result = unsignedLoad ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// -----------------------------------------------------------------------------
// dmem_bytelane
// MEM-stage data memory with byte/half/word stores and loads, registered
// reads with a valid strobe, misalignment rejection and a sequential
// clear-on-reset engine.
// Optional feature: define DMEM_WRITE_FWD_EN so that a load issued in the
// same cycle as a store returns the merged post-store word; otherwise the
// load sees the pre-store contents.
// Ports:
//   clk          in  1       clock, all state changes on posedge
//   reset        in  1       synchronous active-high reset
//   address      in  ADDR_W  byte address (wraps modulo 4*DEPTH)
//   memWrite     in  1       store request
//   memRead      in  1       load request
//   size         in  2       00 byte, 01 half, 10 word, 11 treated as word
//   unsignedLoad in  1       1 = zero-extend, 0 = sign-extend
//   writeData    in  32      store data, right-justified
//   readData     out 32      registered load result
//   readValid    out 1       pulse: readData updated
//   misaligned   out 1       pulse: previous request rejected
//   busy         out 1       clear engine active, requests dropped
// -----------------------------------------------------------------------------
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [1:0]        size,
  input  logic              unsignedLoad,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              misaligned,
  output logic              busy
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [31:0]      mem_r [DEPTH];
  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] cnt_r;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic             mis_s;
  logic             ready_s;
  logic             do_store_s;
  logic             do_load_s;
  logic             mis_pulse_s;
  logic [31:0]      old_word_s;
  logic [3:0]       lane_en_s;
  logic [31:0]      lane_data_s;
  logic [31:0]      merged_s;
  logic [31:0]      load_word_s;
  logic [31:0]      load_res_s;
  logic             unused_addr_s;

  // Upper address bits are ignored on purpose; this gives the modulo wrap.
  assign unused_addr_s = ^address[ADDR_W-1:IDX_W+2];

  assign idx_s       = address[IDX_W+1:2];
  assign off_s       = address[1:0];
  assign mis_s       = is_misaligned(size, off_s);
  assign ready_s     = (state_r == ST_READY);
  assign do_store_s  = ready_s & ~mis_s & memWrite;
  assign do_load_s   = ready_s & ~mis_s & memRead;
  assign mis_pulse_s = ready_s & mis_s & (memRead | memWrite);
  assign old_word_s  = mem_r[idx_s];

  // State register; reset restarts the clear engine when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: state_nxt_s = (cnt_r == LAST_IDX) ? ST_READY : ST_CLEAR;
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_READY;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      ST_CLEAR: busy = 1'b1;
      ST_READY: busy = 1'b0;
      default:  busy = 1'b0;
    endcase
  end

  // Clear-engine word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Store lane enables and replicated data, merged with the current word.
  always_comb begin
    lane_en_s   = 4'b0000;
    lane_data_s = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        lane_en_s   = 4'b0001 << off_s;
        lane_data_s = {4{writeData[7:0]}};
      end
      SZ_HALF: begin
        lane_en_s   = off_s[1] ? 4'b1100 : 4'b0011;
        lane_data_s = {2{writeData[15:0]}};
      end
      default: begin
        lane_en_s   = 4'b1111;
        lane_data_s = writeData;
      end
    endcase
    merged_s = old_word_s;
    for (int l = 0; l < 4; l++) begin
      if (lane_en_s[l]) begin
        merged_s[8*l +: 8] = lane_data_s[8*l +: 8];
      end else begin
        merged_s[8*l +: 8] = old_word_s[8*l +: 8];
      end
    end
  end

`ifdef DMEM_WRITE_FWD_EN
  // Same address means same word, so a concurrent store is always a hit.
  assign load_word_s = do_store_s ? merged_s : old_word_s;
`else
  assign load_word_s = old_word_s;
`endif

  dmem_load_align u_load_align (
    .word         (load_word_s),
    .offset       (off_s),
    .size         (size),
    .unsignedLoad (unsignedLoad),
    .result       (load_res_s)
  );

  // Memory array: clear engine writes zeros, READY applies merged stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_CLEAR) begin
        mem_r[cnt_r] <= 32'h0000_0000;
      end else if (do_store_s) begin
        mem_r[idx_s] <= merged_s;
      end
    end
  end

  // Registered load result and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData   <= 32'h0000_0000;
      readValid  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      readValid  <= do_load_s;
      misaligned <= mis_pulse_s;
      if (do_load_s) begin
        readData <= load_res_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// -----------------------------------------------------------------------------
// tb_dmem_bytelane
// Directed, table-driven bench for dmem_bytelane (DEPTH=32, clear on reset).
// Expected results for the same-cycle load/store depend on DMEM_WRITE_FWD_EN.
// -----------------------------------------------------------------------------
module tb_dmem_bytelane;

  typedef struct {
    logic        mw;
    logic        mr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        exp_m;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        readValid;
  logic        misaligned;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  dmem_bytelane #(.DEPTH(32), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .size         (size),
    .unsignedLoad (unsignedLoad),
    .writeData    (writeData),
    .readData     (readData),
    .readValid    (readValid),
    .misaligned   (misaligned),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic mw, logic mr, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic v, logic m);
    vec_t t;
    t.mw = mw; t.mr = mr; t.sz = sz; t.uns = uns; t.addr = a; t.wd = wd;
    t.exp_rd = rd; t.exp_v = v; t.exp_m = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memWrite = 1'b0; memRead = 1'b0; size = 2'b10; unsignedLoad = 1'b0;
    address = 32'h0; writeData = 32'h0;
  endtask

  // One request cycle; outputs sampled 1 time unit after the edge.
  task automatic step(input logic mw, input logic mr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
    memWrite = mw; memRead = mr; size = sz; unsignedLoad = uns;
    address = a; writeData = wd;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Count cycles until busy drops (bounded); optionally hammer requests.
  task automatic count_busy(input logic drive, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (drive) begin
        memWrite = 1'b1; memRead = 1'b1; size = 2'b10; address = 32'h0;
        writeData = 32'hCAFE_F00D;
      end
      @(posedge clk); #1;
      idle_inputs();
      if (drive) begin
        chk("busy_no_valid", {31'h0, readValid}, 32'h0);
        chk("busy_no_mis", {31'h0, misaligned}, 32'h0);
      end
      n++;
    end
  endtask

  initial begin
    int nb;
    logic [31:0] exp_fwd;
`ifdef DMEM_WRITE_FWD_EN
    exp_fwd = 32'h5555_5555;
`else
    exp_fwd = 32'hAAAA_AAAA;
`endif
    //            mw    mr    sz     uns   addr          wdata          exp_rd         v     m
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_007C, 32'h0,         32'h0000_0000, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_0033, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0011, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_1122, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0044, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0080, 32'h0000_0044, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_8000, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h0000_0080, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_BEEF, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_BEEF, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_8000, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h1234_5678, 32'hBEEF_8000, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_8000, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'h0,         32'hBEEF_8000, 1'b0, 1'b1));
    vq.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_1111, 32'hBEEF_8000, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0030, 32'hCAFE_BABE, 32'h0000_0080, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0030, 32'h0,         32'hCAFE_BABE, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_BABE, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h5555_5555, exp_fwd,       1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         32'h5555_5555, 1'b1, 1'b0));

    // Reset pulse and clear window with requests that must be dropped.
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_rd", readData, 32'h0);
    chk("rst_valid", {31'h0, readValid}, 32'h0);
    chk("rst_mis", {31'h0, misaligned}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    count_busy(1'b1, nb);
    chk("busy_cycles", nb, 32);

    // Table-driven single-cycle requests.
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].mw, vq[i].mr, vq[i].sz, vq[i].uns, vq[i].addr, vq[i].wd);
      chk($sformatf("v%0d rd", i), readData, vq[i].exp_rd);
      chk($sformatf("v%0d valid", i), {31'h0, readValid}, {31'h0, vq[i].exp_v});
      chk($sformatf("v%0d mis", i), {31'h0, misaligned}, {31'h0, vq[i].exp_m});
    end

    // Reset re-asserted in clear cycle 10 restarts the full clear.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_rd", readData, 32'h0);
    chk("rst2_busy", {31'h0, busy}, 32'h1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mid_clear_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy(1'b0, nb);
    chk("busy_cycles_restart", nb, 32);
    for (int w = 0; w < 32; w++) begin
      step(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0);
      chk($sformatf("clr_w%0d", w), readData, 32'h0);
      chk($sformatf("clr_v%0d", w), {31'h0, readValid}, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
